// File: rtl/spi_bus_ctrl.sv
// Purpose: decodes the SPI gateway address onto one of NPORTS byte ports, qualifies strobes, muxes read data.
// Latency: TXD, PORT_RXE/PORT_RXD and BYTE_IDX one cycle after TXE/RXE; PORT_TXE combinational.
// Backpressure: none, the gateway paces bytes; a port idle for TIMEOUT cycles is dropped (STALL).
//
// Ports: CLK/RST (async, active-high); gateway side ADDR, SEL, TXE, RXE, RXD in and TXD out;
// port side PORT_SEL, PORT_RXE, PORT_TXE, PORT_RXD out and PORT_TXD (8 bits per lane) in;
// BYTE_IDX byte position in the transaction; ERR sticky {timeout, unmapped}, cleared by CLR_ERR.
// Optional feature macro: SPI_BUS_CTRL_STATUS_EN adds a read-to-clear status register at STATUS_ADDR.
module spi_bus_ctrl #(
  parameter int         NPORTS      = 4,
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         TIMEOUT     = 50000,
  parameter logic [7:0] STATUS_ADDR = 8'hFF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          ADDR,
  input  logic                SEL,
  input  logic                TXE,
  input  logic                RXE,
  input  logic [7:0]          RXD,
  output logic [7:0]          TXD,
  output logic [NPORTS-1:0]   PORT_SEL,
  output logic [NPORTS-1:0]   PORT_RXE,
  output logic [NPORTS-1:0]   PORT_TXE,
  output logic [7:0]          PORT_RXD,
  input  logic [8*NPORTS-1:0] PORT_TXD,
  output logic [7:0]          BYTE_IDX,
  input  logic                CLR_ERR,
  output logic [1:0]          ERR
);

  localparam int            IW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_UNMAPPED, S_STALL} state_t;
  state_t state, state_nxt;

  // Address decode, sampled while SEL is low so it is stable for the whole transaction.
  logic [7:0]        addr_off;
  logic              port_match, stat_match;
  logic              dec_hit, dec_stat;
  logic [IW-1:0]     dec_idx;
  logic [NPORTS-1:0] idx_oh;
  logic [7:0]        lane;
  logic [CW-1:0]     idle_cnt;
  logic              idle_ev, timeout_hit, rx_ok;
  logic [1:0]        err_set, err_clr, err_nxt;

  assign addr_off   = ADDR - BASE_ADDR;
  assign port_match = (int'(addr_off) < NPORTS);
`ifdef SPI_BUS_CTRL_STATUS_EN
  localparam logic [3:0] NP_M1 = 4'(NPORTS - 1);
  logic       stat_rd;
  logic [7:0] stat_byte;
  assign stat_match = (ADDR == STATUS_ADDR);
  assign stat_byte  = {ERR, 2'b00, NP_M1};
`else
  assign stat_match = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_hit  <= 1'b0;
      dec_stat <= 1'b0;
      dec_idx  <= '0;
    end else if (!SEL) begin
      dec_hit  <= port_match | stat_match;
      dec_stat <= stat_match & ~port_match;
      dec_idx  <= addr_off[IW-1:0];
    end
  end

  assign idx_oh = NPORTS'(1) << dec_idx;

  // Read-lane mux; a loop keeps out-of-range indices (status decode) harmless.
  always_comb begin
    lane = 8'hFF;
    for (int i = 0; i < NPORTS; i++) begin
      if (dec_idx == IW'(i)) lane = PORT_TXD[8*i +: 8];
    end
  end

  assign idle_ev     = SEL & ~RXE & ~TXE;
  // Fires on the TIMEOUT-th consecutive idle cycle spent in ACTIVE.
  assign timeout_hit = (state == S_ACTIVE) & idle_ev & (idle_cnt == CNT_LAST);
  assign rx_ok       = RXE & SEL & (state == S_ACTIVE) & ~dec_stat;
  assign PORT_TXE    = (TXE && state == S_ACTIVE && !dec_stat) ? idx_oh : '0;

  always_comb begin
    state_nxt = state;
    err_set   = 2'b00;
    err_clr   = {2{CLR_ERR}};
    if (!SEL) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (dec_hit) begin
            state_nxt = S_ACTIVE;
          end else begin
            state_nxt  = S_UNMAPPED;
            err_set[0] = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (timeout_hit) begin
            state_nxt  = S_STALL;
            err_set[1] = 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef SPI_BUS_CTRL_STATUS_EN
    // SEL falling after a status read clears the error bits.
    if (stat_rd && !SEL && state != S_IDLE) err_clr = 2'b11;
`endif
    // A set in the same cycle as a clear wins.
    err_nxt = err_set | (ERR & ~err_clr);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      TXD      <= 8'hFF;
      PORT_SEL <= '0;
      PORT_RXE <= '0;
      PORT_RXD <= 8'h00;
      BYTE_IDX <= 8'h00;
      ERR      <= 2'b00;
      idle_cnt <= '0;
`ifdef SPI_BUS_CTRL_STATUS_EN
      stat_rd  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ERR      <= err_nxt;
      PORT_SEL <= (state_nxt == S_ACTIVE && !dec_stat) ? idx_oh : '0;
      PORT_RXE <= rx_ok ? idx_oh : '0;
      if (rx_ok) PORT_RXD <= RXD;

      if (!SEL || RXE || TXE) idle_cnt <= '0;
      else if (state == S_ACTIVE && idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + 1'b1;

      if (!SEL) BYTE_IDX <= 8'h00;
      else if (RXE && BYTE_IDX != 8'hFF) BYTE_IDX <= BYTE_IDX + 8'h01;

      if (TXE) begin
        if (state == S_ACTIVE) begin
`ifdef SPI_BUS_CTRL_STATUS_EN
          TXD <= dec_stat ? stat_byte : lane;
`else
          TXD <= lane;
`endif
        end else if (state == S_UNMAPPED || state == S_STALL) begin
          TXD <= 8'hFF;
        end
      end

`ifdef SPI_BUS_CTRL_STATUS_EN
      if (!SEL) stat_rd <= 1'b0;
      else if (TXE && state == S_ACTIVE && dec_stat) stat_rd <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Testbench for spi_bus_ctrl: scoreboard queues filled by the stimulus, drained by a negedge monitor.
module tb_spi_bus_ctrl;

  localparam int         NPORTS  = 4;
  localparam logic [7:0] BASE    = 8'h10;
  localparam int         TIMEOUT = 16;
  localparam int         K_NONE  = 0;
  localparam int         K_PORT  = 1;
  localparam int         K_STAT  = 2;
`ifdef SPI_BUS_CTRL_STATUS_EN
  localparam bit STATUS_ON = 1'b1;
`else
  localparam bit STATUS_ON = 1'b0;
`endif

  logic                clk, rst, sel, txe, rxe, clr_err;
  logic [7:0]          addr, rxd, txd, port_rxd, byte_idx;
  logic [NPORTS-1:0]   port_sel, port_rxe, port_txe;
  logic [8*NPORTS-1:0] port_txd;
  logic [1:0]          err;

  spi_bus_ctrl #(.NPORTS(NPORTS), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT), .STATUS_ADDR(8'hFF)) dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .SEL(sel), .TXE(txe), .RXE(rxe), .RXD(rxd), .TXD(txd),
    .PORT_SEL(port_sel), .PORT_RXE(port_rxe), .PORT_TXE(port_txe), .PORT_RXD(port_rxd),
    .PORT_TXD(port_txd), .BYTE_IDX(byte_idx), .CLR_ERR(clr_err), .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [11:0]       wr_q[$];      // {port, data} expected on PORT_RXE/PORT_RXD
  logic [NPORTS-1:0] rd_oh_q[$];   // expected PORT_TXE with each TXE
  logic [7:0]        rd_val_q[$];  // byte the host should receive for each TXE
  logic [1:0]        m_err = 2'b00;
  int                cur_kind, cur_idx, cur_nb;
  bit                stat_read;

  // Monitor-private state.
  logic              txd_pend = 1'b0;
  logic [7:0]        txd_exp;
  logic [11:0]       mon_e;
  logic [NPORTS-1:0] mon_oh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NPORTS-1:0] oh(input int i);
    return NPORTS'(1) << i;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (txd_pend) begin
        check("host_rx_txd", {24'h0, txd}, {24'h0, txd_exp});
        txd_pend = 1'b0;
      end
      if (port_rxe != '0) begin
        if (wr_q.size() == 0) begin
          check("unexpected_port_rxe", port_rxe, 0);
        end else begin
          mon_e = wr_q.pop_front();
          check("port_rxe", port_rxe, oh(int'(mon_e[11:8])));
          check("port_rxd", port_rxd, mon_e[7:0]);
        end
      end
      if (txe) begin
        if (rd_oh_q.size() == 0) begin
          check("rd_queue_level", rd_oh_q.size(), 1);
        end else begin
          mon_oh   = rd_oh_q.pop_front();
          txd_exp  = rd_val_q.pop_front();
          check("port_txe", port_txe, mon_oh);
          txd_pend = 1'b1;
        end
      end
    end
  end

  task automatic start_trans(input logic [7:0] a);
    logic [7:0]        off;
    logic [NPORTS-1:0] exp_sel;
    addr = a;
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    off       = a - BASE;
    cur_nb    = 0;
    stat_read = 1'b0;
    if (int'(off) < NPORTS) begin
      cur_kind = K_PORT;
      cur_idx  = int'(off);
    end else if (STATUS_ON && a == 8'hFF) begin
      cur_kind = K_STAT;
    end else begin
      cur_kind = K_NONE;
      m_err[0] = 1'b1;
    end
    exp_sel = (cur_kind == K_PORT) ? oh(cur_idx) : '0;
    check("port_sel", port_sel, exp_sel);
    check("err_on_sel", err, m_err);
    check("byte_idx_start", byte_idx, 0);
  endtask

  task automatic do_byte(input bit do_rd, input bit do_wr, input logic [7:0] d);
    if (do_rd) begin
      if (cur_kind == K_PORT) begin
        rd_oh_q.push_back(oh(cur_idx));
        rd_val_q.push_back(port_txd[8*cur_idx +: 8]);
      end else if (cur_kind == K_STAT) begin
        rd_oh_q.push_back('0);
        rd_val_q.push_back({m_err, 2'b00, 4'(NPORTS - 1)});
        stat_read = 1'b1;
      end else begin
        rd_oh_q.push_back('0);
        rd_val_q.push_back(8'hFF);
      end
      txe = 1'b1;
      @(posedge clk); #1;
      txe = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    if (do_wr) begin
      if (cur_kind == K_PORT) wr_q.push_back({4'(cur_idx), d});
      rxe = 1'b1;
      rxd = d;
      @(posedge clk); #1;
      rxe = 1'b0;
      if (cur_nb < 255) cur_nb++;
      check("byte_idx", byte_idx, cur_nb);
      @(posedge clk); #1;
    end
  endtask

  task automatic end_trans();
    sel = 1'b0;
    @(posedge clk); #1;
    if (cur_kind == K_STAT && stat_read) m_err = 2'b00;
    check("port_sel_idle", port_sel, 0);
    check("byte_idx_idle", byte_idx, 0);
    check("err_idle", err, m_err);
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    m_err   = 2'b00;
    check("err_cleared", err, m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r, nb, k;
    logic [7:0]  a;
    rst = 1'b1; sel = 1'b0; txe = 1'b0; rxe = 1'b0; clr_err = 1'b0;
    addr = 8'h00; rxd = 8'h00; port_txd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 8'hFF);
    check("rst_port_sel", port_sel, 0);
    check("rst_port_rxe", port_rxe, 0);
    check("rst_port_txe", port_txe, 0);
    check("rst_port_rxd", port_rxd, 0);
    check("rst_byte_idx", byte_idx, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write two bytes to port 1.
    start_trans(8'h11);
    do_byte(1'b0, 1'b1, 8'hA5);
    do_byte(1'b0, 1'b1, 8'h3C);
    end_trans();

    // Read port 3.
    port_txd[8*3 +: 8] = 8'h5A;
    start_trans(8'h13);
    do_byte(1'b1, 1'b0, 8'h00);
    end_trans();

    // Unmapped access, then clear.
    start_trans(8'h20);
    do_byte(1'b1, 1'b1, 8'h77);
    end_trans();
    clear_err();

    // Stall after TIMEOUT idle cycles in ACTIVE.
    start_trans(8'h10);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("pre_stall_port_sel", port_sel, oh(0));
    check("pre_stall_err", err, m_err);
    @(posedge clk); #1;
    m_err[1] = 1'b1;
    cur_kind = K_NONE;
    check("stall_port_sel", port_sel, 0);
    check("stall_err", err, m_err);
    do_byte(1'b1, 1'b1, 8'h66);
    end_trans();
    clear_err();

    // SEL falling together with RXE: byte dropped.
    start_trans(8'h12);
    sel = 1'b0; rxe = 1'b1; rxd = 8'h99;
    @(posedge clk); #1;
    rxe = 1'b0;
    check("seldrop_port_rxe", port_rxe, 0);
    check("seldrop_port_sel", port_sel, 0);
    check("seldrop_byte_idx", byte_idx, 0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      for (int l = 0; l < NPORTS; l++) port_txd[8*l +: 8] = 8'($urandom);
      r = $urandom_range(0, 5);
      a = (r < 4) ? BASE + 8'(r) : 8'($urandom_range(0, 255));
      start_trans(a);
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        k = $urandom_range(1, 3);
        do_byte(k[0], k[1], 8'($urandom));
      end
      end_trans();
      if ($urandom_range(0, 3) == 0) clear_err();
    end

`ifdef SPI_BUS_CTRL_STATUS_EN
    // Status read reports {ERR, 00, NPORTS-1} and clears ERR when SEL falls.
    start_trans(8'h20);
    end_trans();
    start_trans(8'hFF);
    do_byte(1'b1, 1'b1, 8'h55);
    end_trans();
`endif

    // Reset asserted mid-byte with an error pending.
    start_trans(8'h20);
    end_trans();
    port_txd[8*1 +: 8] = 8'h3C;
    start_trans(8'h11);
    do_byte(1'b1, 1'b1, 8'h42);
    rxe = 1'b1; rxd = 8'hE7;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rxe = 1'b0; sel = 1'b0;
    check("midrst_txd", txd, 8'hFF);
    check("midrst_port_sel", port_sel, 0);
    check("midrst_port_rxe", port_rxe, 0);
    check("midrst_port_rxd", port_rxd, 0);
    check("midrst_byte_idx", byte_idx, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_err = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_oh_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
